// File: rtl/fib_sched.sv
// fib_sched: round-robin scheduler sharing one Fibonacci term generator among NREQ requesters.
// Define FIB_SCHED_SAT_EN to saturate terms at all-ones instead of wrapping modulo 2^WIDTH.
module fib_sched #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2,
    parameter int CNT_W = 4,
    parameter int ID_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CNT_W-1:0] req_len,
    output logic [NREQ-1:0]       grant,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [ID_W-1:0]       out_id,
    output logic                  out_last,
    output logic                  ovf,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, RUN, SKIP} state_t;
    state_t           state;
    logic [WIDTH-1:0] b, next_b;
    logic             cb, flag, found;
    logic [WIDTH:0]   sum;
    logic [CNT_W-1:0] rem, sel_len;
    logic [ID_W-1:0]  p, k;
    // first asserted requester at or after the pointer, wrapping
    always_comb begin
        found = 1'b0;
        k = '0;
        sel_len = '0;
        for (int i = 0; i < NREQ; i++)
            for (int j = 0; j < NREQ; j++)
                if (!found && req[j] && (int'(p) + i) % NREQ == j) begin
                    found = 1'b1;
                    k = ID_W'(j);
                    sel_len = req_len[j*CNT_W +: CNT_W];
                end
    end
    // cb marks b's true value as >= 2^WIDTH; ovf does the same for the displayed term
    assign sum  = {1'b0, out_data} + {1'b0, b};
    assign flag = sum[WIDTH] | ovf | cb;
`ifdef FIB_SCHED_SAT_EN
    assign next_b = flag ? '1 : sum[WIDTH-1:0];
`else
    assign next_b = sum[WIDTH-1:0];
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            out_last  <= 1'b0;
            ovf       <= 1'b0;
            busy      <= 1'b0;
            b         <= '0;
            cb        <= 1'b0;
            rem       <= '0;
            p         <= '0;
        end else begin
            grant <= '0;
            if (state == IDLE) begin
                if (found) begin
                    grant     <= NREQ'(1) << k;
                    out_id    <= k;
                    p         <= (int'(k) == NREQ - 1) ? '0 : k + 1'b1;
                    out_data  <= '0;
                    b         <= WIDTH'(1);
                    cb        <= 1'b0;
                    ovf       <= 1'b0;
                    rem       <= sel_len;
                    out_last  <= sel_len == CNT_W'(1);
                    out_valid <= sel_len != '0;
                    busy      <= 1'b1;
                    state     <= sel_len != '0 ? RUN : SKIP;
                end
            end else if (state == RUN) begin
                if (out_ready) begin
                    out_data <= b;
                    ovf      <= ovf | cb;
                    b        <= next_b;
                    cb       <= flag;
                    rem      <= rem - 1'b1;
                    out_last <= rem == CNT_W'(2);
                    if (out_last) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
            end else begin
                busy  <= 1'b0;
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_fib_sched.sv
// tb_fib_sched: directed stimulus for fib_sched with a run-level beat model and a per-cycle compare thread.
module tb_fib_sched;
    logic       clk = 1'b0;
    logic       rst, out_ready, out_valid, out_last, ovf, busy;
    logic [1:0] req, grant, out_id;
    logic [7:0] req_len, out_data;
    int         n_checks = 0, n_fail = 0;

    typedef struct {int data; int id; int last; int ovf;} beat_t;
    beat_t q[$];

    fib_sched #(.WIDTH(8), .NREQ(2), .CNT_W(4), .ID_W(2)) dut (
        .clk(clk), .rst(rst), .req(req), .req_len(req_len), .grant(grant),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_id(out_id), .out_last(out_last), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // expected beats from true Fibonacci values, reduced by wrap or saturation
    task automatic push_run(input int id, input int len);
        int t0 = 0, t1 = 1, t;
        for (int i = 0; i < len; i++) begin
            beat_t e;
`ifdef FIB_SCHED_SAT_EN
            e.data = t0 >= 256 ? 255 : t0;
`else
            e.data = t0 % 256;
`endif
            e.id = id;
            e.last = (i == len - 1);
            e.ovf = (t0 >= 256);
            q.push_back(e);
            t = t0;
            t0 = t1;
            t1 = t + t1;
        end
    endtask

    task automatic drain;
        for (int i = 0; i < 80 && (q.size() != 0 || busy); i++) tick;
        check("drain_queue_empty", q.size(), 0);
        check("drain_busy", int'(busy), 0);
    endtask

    initial begin
        int pat[7] = '{1, 0, 0, 1, 0, 1, 1};
        int g_exp[10] = '{1, 0, 0, 2, 0, 0, 0, 1, 0, 0};
        int b_exp[10] = '{1, 1, 0, 1, 1, 1, 0, 1, 1, 0};
        rst = 1'b1; req = '0; req_len = '0; out_ready = 1'b0;
        fork
            forever begin
                @(negedge clk);
                if (!rst && out_valid) begin
                    if (q.size() == 0) check("unexpected_beat", 1, 0);
                    else begin
                        check("beat_data", int'(out_data), q[0].data);
                        check("beat_id", int'(out_id), q[0].id);
                        check("beat_last", int'(out_last), q[0].last);
                        check("beat_ovf", int'(ovf), q[0].ovf);
                        if (out_ready) void'(q.pop_front());
                    end
                end
            end
        join_none
        tick; tick;
        check("rst_grant", int'(grant), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_data", int'(out_data), 0);
        check("rst_id", int'(out_id), 0);
        check("rst_last", int'(out_last), 0);
        check("rst_ovf", int'(ovf), 0);
        rst = 1'b0;

        // basic run of 5
        push_run(0, 5);
        req = 2'b01; req_len = {4'd0, 4'd5}; out_ready = 1'b1;
        tick;
        check("basic_grant", int'(grant), 1);
        check("basic_first_valid", int'(out_valid), 1);
        req = '0;
        tick;
        check("basic_grant_pulse", int'(grant), 0);
        tick; tick; tick;
        check("basic_last_data", int'(out_data), 3);
        check("basic_last_flag", int'(out_last), 1);
        tick;
        check("basic_busy_drop", int'(busy), 0);
        check("basic_valid_drop", int'(out_valid), 0);
        drain;

        // backpressure, len 4
        push_run(0, 4);
        req = 2'b01; req_len = {4'd0, 4'd4};
        tick;
        req = '0;
        for (int i = 0; i < 7; i++) begin
            out_ready = pat[i][0];
            tick;
        end
        check("bp_valid_after", int'(out_valid), 0);
        out_ready = 1'b1;
        drain;

        // round robin from a fresh pointer
        rst = 1'b1; tick; rst = 1'b0;
        push_run(0, 2); push_run(1, 3); push_run(0, 2);
        req = 2'b11; req_len = {4'd3, 4'd2};
        tick;
        for (int c = 0; c < 10; c++) begin
            check("rr_grant", int'(grant), g_exp[c]);
            check("rr_busy", int'(busy), b_exp[c]);
            if (c == 7) req = '0;
            tick;
        end
        drain;

        // overflow run of 15, then a clean run of 2
        push_run(0, 15);
        req = 2'b01; req_len = {4'd0, 4'd15};
        tick;
        req = '0;
        for (int i = 0; i < 40 && !(out_valid && out_last); i++) tick;
        check("ovf_last_flag", int'(out_last), 1);
        check("ovf_flag", int'(ovf), 1);
`ifdef FIB_SCHED_SAT_EN
        check("ovf_last_data", int'(out_data), 255);
`else
        check("ovf_last_data", int'(out_data), 121);
`endif
        drain;
        push_run(0, 2);
        req = 2'b01; req_len = {4'd0, 4'd2};
        tick;
        req = '0;
        check("ovf_cleared", int'(ovf), 0);
        drain;

        // zero-length request still grants and advances the pointer
        rst = 1'b1; tick; rst = 1'b0;
        req = 2'b01; req_len = {4'd1, 4'd0};
        tick;
        check("zero_grant", int'(grant), 1);
        check("zero_valid", int'(out_valid), 0);
        check("zero_busy", int'(busy), 1);
        req = '0;
        tick;
        check("zero_busy_after", int'(busy), 0);
        check("zero_valid_after", int'(out_valid), 0);
        push_run(1, 1);
        req = 2'b11; req_len = {4'd1, 4'd1};
        tick;
        check("zero_ptr_grant", int'(grant), 2);
        check("zero_ptr_id", int'(out_id), 1);
        req = '0;
        drain;

        // reset in the middle of a run
        push_run(0, 5);
        req = 2'b01; req_len = {4'd0, 4'd5};
        tick;
        req = '0;
        tick; tick; tick;
        check("mid_beat3_data", int'(out_data), 2);
        rst = 1'b1;
        q.delete();
        tick;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_grant", int'(grant), 0);
        rst = 1'b0;
        push_run(0, 1);
        req = 2'b11; req_len = {4'd1, 4'd1};
        tick;
        check("post_rst_grant", int'(grant), 1);
        req = '0;
        drain;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fib_sched.md
Name: fib_sched

Overview:
- Schedules one shared Fibonacci term generator among NREQ requesters.
- Each requester asks for a run of N terms, always starting from F(0)=0.
- Requests are arbitrated round-robin. The granted run is streamed out on a valid/ready interface, tagged with the requester id and a last-beat marker.
- Sits between the fibonacci datapath consumers and the generator, which is instantiated internally.

Parameters:
- WIDTH, 8: term width in bits. Arithmetic is modulo 2^WIDTH.
- NREQ, 2: number of requesters, range 2..4.
- CNT_W, 4: width of each length field. Maximum run is 2^CNT_W-1 terms.
- ID_W, 2: width of out_id. Must satisfy 2^ID_W >= NREQ.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request, level; held until own grant bit seen
- req_len  in  NREQ*CNT_W  requested term count; slice i belongs to requester i
- grant  out  NREQ  one-hot; one-cycle pulse acknowledging acceptance
- out_valid  out  1  term available
- out_ready  in  1  consumer accepts term
- out_data  out  WIDTH  current term
- out_id  out  ID_W  index of the requester owning the current run
- out_last  out  1  current beat is the final term of the run
- ovf  out  1  sticky overflow flag for the current run
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer gives requester 0 top priority.
- Reset mid-run aborts immediately; no further beats are produced.
- States: IDLE, RUN, SKIP.
- IDLE:
  - At a rising edge, scan req starting at pointer p and wrapping; pick the first asserted index k.
  - Capture len=req_len[k], set out_id=k, load internal a=0, b=1, clear ovf.
  - Pointer p becomes (k+1) mod NREQ.
  - grant[k]=1 for exactly the following cycle.
  - If len != 0, go to RUN; if len == 0, go to SKIP.
  - No request asserted: stay in IDLE; grant stays 0.
- SKIP: one cycle with no beat, then back to IDLE. The grant pulse still occurs and the pointer still advances.
- RUN: out_valid=1, out_data=a, out_last=(remaining==1).
- On out_valid && out_ready:
  - a<=b, b<=(a+b) mod 2^WIDTH; remaining decrements.
  - If out_last, go to IDLE; out_valid is 0 next cycle.
- Backpressure: while out_ready=0, out_data, out_id, out_last and ovf hold stable. Terms are never skipped or repeated.
- Latency: first beat is valid in the same cycle as the grant pulse, one cycle after req is sampled.
- Turnaround: minimum one IDLE cycle between runs, so back-to-back runs are spaced by one idle cycle.
- Overflow:
  - A carry bit is stored alongside each generated term.
  - ovf rises in the cycle out_data first presents a term whose true value is at least 2^WIDTH.
  - ovf stays high to the end of the run and clears on the next grant.
- In RUN, req changes and req_len changes are ignored; arbitration happens only in IDLE.
- A requester that holds req after its grant is eligible again only after all other asserted requesters (round-robin fairness).

Optional Feature:
- Macro FIB_SCHED_SAT_EN.
- When defined: a sum at or above 2^WIDTH saturates to all-ones instead of wrapping, and all later terms in the run stay all-ones. ovf behaves identically.
- When undefined: modulo wrap as above.

Test Plan (WIDTH=8, NREQ=2, CNT_W=4):
- Basic run: req[0]=1, len0=5, out_ready=1.
  - Expect grant=01 for one cycle.
  - Expect out_data 0,1,1,2,3 on consecutive cycles, out_id=0, out_last only on 3, ovf=0.
  - busy drops the cycle after the last beat.
- Backpressure: len0=4; out_ready toggles 1,0,0,1,0,1,1.
  - Expect exactly the beats 0,1,1,2, each held stable while stalled; out_last on 2.
- Round-robin: req=11 held, len0=2, len1=3.
  - Expect order: run id0 (0,1), then id1 (0,1,1), then id0 again.
  - Expect a grant pulse per run and one IDLE cycle between runs.
- Overflow wrap, macro off: len0=15.
  - Expect terms 0,1,1,2,3,5,8,13,21,34,55,89,144,233,121.
  - ovf rises with the beat 121; out_last on that beat.
  - A following run of len 2 shows ovf=0.
- Saturation, macro on: len0=15.
  - Last two beats are 233 then 255; ovf=1 on 255.
- Corner cases:
  - len0=0: grant pulse, no out_valid, pointer advances.
  - rst asserted mid-run on beat 3: next cycle out_valid=0, busy=0, grant=0.
  - After that reset, req=11 grants requester 0 first.
